ray_scan_ctrl: RTL and testbench
================================

RAY_SCAN_CTRL -- requirements
Module: ray_scan_ctrl

Interface
REQ-001 Parameter NTOTAL_BITS SHALL default to 16 and set the coordinate word width.
REQ-002 Parameter NFRAC_BITS SHALL default to 4 and set the fractional bits of the coordinate word (signed 12.4).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: single-cycle frame start request.
REQ-006 Port abort, input, 1: terminates the current frame.
REQ-007 Port img_w, input, 12: frame width in pixels.
REQ-008 Port img_h, input, 12: frame height in pixels.
REQ-009 Port c2w_ld, output, 1: one-cycle strobe; the ray datapath latches its camera-to-world matrix and intrinsics.
REQ-010 Port pix_valid, output, 1: coordinate pair valid toward the ray datapath.
REQ-011 Port pix_ready, input, 1: ray datapath accepts the coordinate pair.
REQ-012 Port L_i, output, NTOTAL_BITS: column coordinate (x), signed fixed point.
REQ-013 Port L_j, output, NTOTAL_BITS: row coordinate (y), signed fixed point.
REQ-014 Port last, output, 1: marks the final pixel of the frame.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle frame-completion pulse.
REQ-017 Port pix_cnt, output, 23: count of accepted coordinate transfers in the current frame.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, SCAN and DONE.
REQ-019 In IDLE with start=1 and abort=0, the block SHALL latch img_w and img_h, clamp each to 2048, clear pix_cnt, x and y, and go to LOAD.
REQ-020 If start is accepted with a latched dimension of zero, the block SHALL go straight to DONE, with no c2w_ld and no pix_valid.
REQ-021 LOAD SHALL last exactly one cycle, assert c2w_ld, then go to SCAN; for start at cycle T, c2w_ld is high at T+1 and pix_valid first rises at T+2.
REQ-022 In SCAN, pix_valid SHALL be 1; a transfer occurs when pix_valid and pix_ready are both 1.
REQ-023 While pix_valid=1 and pix_ready=0, L_i, L_j and last SHALL hold stable.
REQ-024 Scan order: x increments per transfer; at x=W-1, x wraps to 0 and y increments; raster order, row-major.
REQ-025 last SHALL be 1 only when x=W-1 and y=H-1 are presented.
REQ-026 A transfer with last=1 SHALL move the FSM to DONE; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 pix_cnt SHALL increment by 1 per transfer and hold its final value in IDLE until the next accepted start.
REQ-028 Coordinate word: integer part in bits [15:4], fraction in [3:0]; maximum integer value 2047, so the word is never negative.
REQ-029 abort=1 in LOAD, SCAN or DONE SHALL force IDLE on the next edge, with pix_valid=0 and no done pulse.
REQ-030 When abort and start are high together in IDLE, abort SHALL win and start SHALL be ignored.
REQ-031 start outside IDLE SHALL be ignored; changes on img_w and img_h after acceptance SHALL be ignored.

Reset
REQ-032 While rst=1, the FSM SHALL be in IDLE and c2w_ld, pix_valid, last, busy, done, L_i, L_j and pix_cnt SHALL all be 0.
REQ-033 rst asserted mid-frame SHALL abandon the frame immediately, with no done pulse.

Configuration
REQ-034 Macro RAY_PIX_CENTER_EN defined: the fraction field SHALL be 4'b1000 (pixel centre, +0.5).
REQ-035 Macro RAY_PIX_CENTER_EN undefined: the fraction field SHALL be 4'b0000 (pixel corner).

Verification
REQ-036 Scenario: W=3, H=2, pix_ready=1, macro off -> c2w_ld at T+1; L_i/L_j = 0x0000/0x0000, 0x0010/0x0000, 0x0020/0x0000, 0x0000/0x0010, 0x0010/0x0010, 0x0020/0x0010 on T+2..T+7; last at T+7; done at T+8; pix_cnt=6.
REQ-037 Scenario: same frame with macro on -> first word 0x0008/0x0008, last word 0x0028/0x0018.
REQ-038 Scenario: W=2, H=2, pix_ready toggling 1,0,0,1 per cycle -> outputs hold during stalls; exactly 4 transfers; pix_cnt=4.
REQ-039 Scenario: abort after the 2nd transfer of a 4x4 frame -> IDLE next cycle; no done; pix_cnt=2; busy=0.
REQ-040 Scenario: img_w=0 -> done at T+1; c2w_ld and pix_valid never rise.
REQ-041 Scenario: img_w=4095, img_h=1 -> 2048 transfers; final L_i=0x7FF0; last=1 on that transfer.

Source files
------------

// File: rtl/ray_scan_ctrl.sv
// Raster-scan pixel coordinate generator feeding the ray datapath (signed 12.4 words).
// Define RAY_PIX_CENTER_EN to emit pixel-centre coordinates (+0.5) instead of pixel corners.
module ray_scan_ctrl #(
  parameter int NTOTAL_BITS = 16,
  parameter int NFRAC_BITS  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [11:0]            img_w,
  input  logic [11:0]            img_h,
  output logic                   c2w_ld,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [NTOTAL_BITS-1:0] L_i,
  output logic [NTOTAL_BITS-1:0] L_j,
  output logic                   last,
  output logic                   busy,
  output logic                   done,
  output logic [22:0]            pix_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  localparam logic [11:0] MAX_DIM = 12'd2048;

`ifdef RAY_PIX_CENTER_EN
  localparam logic [NTOTAL_BITS-1:0] FRAC_OFS = NTOTAL_BITS'(1) << (NFRAC_BITS - 1);
`else
  localparam logic [NTOTAL_BITS-1:0] FRAC_OFS = '0;
`endif

  state_t      state_q, state_d;
  logic [11:0] w_q, w_d;
  logic [11:0] h_q, h_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [22:0] pix_cnt_q, pix_cnt_d;

  logic [11:0] w_clamp;
  logic [11:0] h_clamp;
  logic        x_at_end;
  logic        y_at_end;
  logic        xfer;

  assign w_clamp  = (img_w > MAX_DIM) ? MAX_DIM : img_w;
  assign h_clamp  = (img_h > MAX_DIM) ? MAX_DIM : img_h;
  assign x_at_end = (x_q == 12'(w_q - 12'd1));
  assign y_at_end = (y_q == 12'(h_q - 12'd1));

  assign c2w_ld    = (state_q == LOAD);
  assign pix_valid = (state_q == SCAN);
  assign xfer      = pix_valid && pix_ready;
  assign last      = pix_valid && x_at_end && y_at_end;
  assign busy      = (state_q != IDLE);
  // A DONE cycle that coincides with abort must not be seen as a completed frame.
  assign done      = (state_q == DONE) && !abort;
  assign pix_cnt   = pix_cnt_q;

  // Coordinates are forced to zero outside SCAN so the centre offset never leaks out in reset or idle.
  assign L_i = pix_valid ? ((NTOTAL_BITS'(x_q) << NFRAC_BITS) | FRAC_OFS) : '0;
  assign L_j = pix_valid ? ((NTOTAL_BITS'(y_q) << NFRAC_BITS) | FRAC_OFS) : '0;

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    x_d       = x_q;
    y_d       = y_q;
    pix_cnt_d = pix_cnt_q;

    if (xfer) begin
      pix_cnt_d = 23'(pix_cnt_q + 23'd1);
      if (x_at_end) begin
        x_d = '0;
        y_d = 12'(y_q + 12'd1);
      end else begin
        x_d = 12'(x_q + 12'd1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          w_d       = w_clamp;
          h_d       = h_clamp;
          x_d       = '0;
          y_d       = '0;
          pix_cnt_d = '0;
          state_d   = ((w_clamp == '0) || (h_clamp == '0)) ? DONE : LOAD;
        end
      end
      LOAD:    state_d = SCAN;
      SCAN:    if (xfer && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

endmodule

// File: tb/tb_ray_scan_ctrl.sv
// Directed self-checking bench for ray_scan_ctrl; honours RAY_PIX_CENTER_EN for expected fractions.
module tb_ray_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [11:0] img_w;
  logic [11:0] img_h;
  logic        c2w_ld;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] L_i;
  logic [15:0] L_j;
  logic        last;
  logic        busy;
  logic        done;
  logic [22:0] pix_cnt;

  int checks_total = 0;
  int checks_passed = 0;

`ifdef RAY_PIX_CENTER_EN
  localparam logic [15:0] FRAC = 16'h0008;
`else
  localparam logic [15:0] FRAC = 16'h0000;
`endif

  ray_scan_ctrl #(.NTOTAL_BITS(16), .NFRAC_BITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .img_w(img_w), .img_h(img_h), .c2w_ld(c2w_ld),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .L_i(L_i), .L_j(L_j), .last(last), .busy(busy),
    .done(done), .pix_cnt(pix_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic startFrame(input logic [11:0] w, input logic [11:0] h);
    img_w = w;
    img_h = h;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
  endtask

  // Expected pixel coordinate words for a 3x2 frame, corner form.
  logic [15:0] exp_li_3x2 [6] = '{16'h0000, 16'h0010, 16'h0020, 16'h0000, 16'h0010, 16'h0020};
  logic [15:0] exp_lj_3x2 [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0010, 16'h0010};
  logic [3:0]  ready_pat = 4'b1001;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
    img_w = '0; img_h = '0;
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", pix_valid, 0);
    checkOutput("rst_c2w", c2w_ld, 0);
    checkOutput("rst_Li", L_i, 0);
    checkOutput("rst_Lj", L_j, 0);
    checkOutput("rst_cnt", pix_cnt, 0);
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    $display("[TB] 3x2 frame, ready held high");
    startFrame(12'd3, 12'd2);
    img_w = 12'd7;
    checkOutput("f1_c2w_T1", c2w_ld, 1);
    checkOutput("f1_valid_T1", pix_valid, 0);
    applyStimulus();
    for (int k = 0; k < 6; k++) begin
      checkOutput("f1_valid", pix_valid, 1);
      checkOutput("f1_Li", L_i, exp_li_3x2[k] | FRAC);
      checkOutput("f1_Lj", L_j, exp_lj_3x2[k] | FRAC);
      checkOutput("f1_last", last, (k == 5) ? 1 : 0);
      if (k == 2) start = 1'b1;
      applyStimulus();
      start = 1'b0;
    end
    checkOutput("f1_done", done, 1);
    checkOutput("f1_valid_done", pix_valid, 0);
    applyStimulus();
    checkOutput("f1_done_gone", done, 0);
    checkOutput("f1_busy_idle", busy, 0);
    checkOutput("f1_cnt", pix_cnt, 6);

    $display("[TB] 2x2 frame, ready pattern 1,0,0,1");
    begin
      int n = 0;
      int cyc = 0;
      int seen_done = 0;
      startFrame(12'd2, 12'd2);
      applyStimulus();
      while (n < 4 && cyc < 20) begin
        pix_ready = ready_pat[3 - (cyc % 4)];
        #1;
        checkOutput("f2_valid", pix_valid, 1);
        checkOutput("f2_Li", L_i, (16'(n % 2) << 4) | FRAC);
        checkOutput("f2_Lj", L_j, (16'(n / 2) << 4) | FRAC);
        checkOutput("f2_last", last, (n == 3) ? 1 : 0);
        if (pix_ready) n++;
        cyc++;
        applyStimulus();
      end
      checkOutput("f2_xfers", n, 4);
      seen_done = done;
      checkOutput("f2_done", seen_done, 1);
      checkOutput("f2_cnt", pix_cnt, 4);
      pix_ready = 1'b1;
      applyStimulus();
    end

    $display("[TB] 4x4 frame aborted after two transfers");
    startFrame(12'd4, 12'd4);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("f3_Li_third", L_i, 16'h0020 | FRAC);
    abort = 1'b1;
    pix_ready = 1'b0;
    checkOutput("f3_cnt_pre", pix_cnt, 2);
    applyStimulus();
    abort = 1'b0;
    pix_ready = 1'b1;
    checkOutput("f3_busy", busy, 0);
    checkOutput("f3_valid", pix_valid, 0);
    checkOutput("f3_done", done, 0);
    checkOutput("f3_cnt", pix_cnt, 2);
    applyStimulus();
    checkOutput("f3_done_later", done, 0);

    $display("[TB] start and abort together");
    img_w = 12'd3; img_h = 12'd2;
    start = 1'b1; abort = 1'b1;
    applyStimulus();
    start = 1'b0; abort = 1'b0;
    checkOutput("sa_busy", busy, 0);
    checkOutput("sa_c2w", c2w_ld, 0);

    $display("[TB] zero width frame");
    startFrame(12'd0, 12'd5);
    checkOutput("z_done", done, 1);
    checkOutput("z_c2w", c2w_ld, 0);
    checkOutput("z_valid", pix_valid, 0);
    applyStimulus();
    checkOutput("z_idle", busy, 0);
    checkOutput("z_valid2", pix_valid, 0);
    checkOutput("z_cnt", pix_cnt, 0);

    $display("[TB] 4095x1 frame clamps to 2048");
    begin
      int xfers = 0;
      int cyc = 0;
      startFrame(12'd4095, 12'd1);
      applyStimulus();
      while (!done && cyc < 2100) begin
        if (pix_valid) begin
          if (xfers == 2047) begin
            checkOutput("w_final_Li", L_i, 16'h7FF0 | FRAC);
            checkOutput("w_final_last", last, 1);
          end else if (xfers == 2046) begin
            checkOutput("w_penult_last", last, 0);
          end
          xfers++;
        end
        cyc++;
        applyStimulus();
      end
      checkOutput("w_done_seen", done, 1);
      checkOutput("w_xfers", xfers, 2048);
      checkOutput("w_cnt", pix_cnt, 2048);
      applyStimulus();
    end

    $display("[TB] reset mid-frame");
    startFrame(12'd3, 12'd2);
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    #1;
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_valid", pix_valid, 0);
    checkOutput("mr_cnt", pix_cnt, 0);
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    checkOutput("mr_done", done, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
